// File: rtl/grey_display_if.sv
// Load/digit bus and LED outputs of the grey_display sequencer.
// The master drives the captured grey digits; the slave shows them.
interface grey_display_if;
    logic       i_load;
    logic [4:0] i_100;
    logic [4:0] i_010;
    logic [4:0] i_001;
    logic [7:0] o_LED;
    logic       o_busy;
    logic       o_err;

    modport master (
        output i_load, i_100, i_010, i_001,
        input  o_LED, o_busy, o_err
    );

    modport slave (
        input  i_load, i_100, i_010, i_001,
        output o_LED, o_busy, o_err
    );
endinterface

// File: rtl/grey_display.sv
// Decodes a captured 3-digit grey count and shows it digit by digit
// on a single seven-segment bus, each digit held for pHOLD cycles.
module grey_display #(
    parameter int pHOLD  = 1000,
    parameter bit pBLANK = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    grey_display_if.slave  bus
);
    localparam int CW = $clog2(pHOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(pHOLD - 1);

    typedef enum logic [2:0] {
        IDLE, D100, D010, D001, GAP
    } state_t;

    function automatic logic [4:0] grey_dec(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [6:0] seg7(input logic [4:0] v);
        logic [6:0] s;
        unique case (v)
            5'd0:    s = 7'h3F;
            5'd1:    s = 7'h06;
            5'd2:    s = 7'h5B;
            5'd3:    s = 7'h4F;
            5'd4:    s = 7'h66;
            5'd5:    s = 7'h6D;
            5'd6:    s = 7'h7D;
            5'd7:    s = 7'h07;
            5'd8:    s = 7'h7F;
            5'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    h_q, h_d;
    logic [4:0]    t_q, t_d;
    logic [4:0]    u_q, u_d;
    logic [7:0]    led_q, led_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic [4:0] dh, dt, du;
    logic       last;
    logic       blank_h, blank_t;

    always_comb begin
        dh      = grey_dec(bus.i_100);
        dt      = grey_dec(bus.i_010);
        du      = grey_dec(bus.i_001);
        last    = (cnt_q == LAST);
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        t_d     = t_q;
        u_d     = u_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.i_load) begin
                    state_d = D100;
                    h_d     = dh;
                    t_d     = dt;
                    u_d     = du;
                    err_d   = (dh > 5'd9) | (dt > 5'd9) | (du > 5'd9);
                end
            end
            D100, D010, D001, GAP: begin
                if (last) begin
                    cnt_d = '0;
                    unique case (state_q)
                        D100:    state_d = D010;
                        D010:    state_d = D001;
                        D001:    state_d = GAP;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Invalid digits are nonzero, so they can never be blanked here.
        blank_h = pBLANK && (h_d == 5'd0);
        blank_t = blank_h && (t_d == 5'd0);

        unique case (state_d)
            D100:    led_d = {1'b1, blank_h ? 7'h00 : seg7(h_d)};
            D010:    led_d = {1'b0, blank_t ? 7'h00 : seg7(t_d)};
            D001:    led_d = {1'b0, seg7(u_d)};
            default: led_d = 8'h00;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            t_q     <= '0;
            u_q     <= '0;
            led_q   <= 8'h00;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            t_q     <= t_d;
            u_q     <= u_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_LED  = led_q;
    assign bus.o_busy = busy_q;
    assign bus.o_err  = err_q;
endmodule

// File: tb/tb_grey_display.sv
// Bench for grey_display: three instances checked against a
// cycle-indexed model, plus directed literal expectations.
module tb_grey_display;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ld  = 3'b000;
    logic [4:0] g100 = 5'd0;
    logic [4:0] g010 = 5'd0;
    logic [4:0] g001 = 5'd0;
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    grey_display_if ifa();
    grey_display_if ifb();
    grey_display_if ifc();

    assign ifa.i_load = ld[0];
    assign ifb.i_load = ld[1];
    assign ifc.i_load = ld[2];
    assign ifa.i_100 = g100;
    assign ifa.i_010 = g010;
    assign ifa.i_001 = g001;
    assign ifb.i_100 = g100;
    assign ifb.i_010 = g010;
    assign ifb.i_001 = g001;
    assign ifc.i_100 = g100;
    assign ifc.i_010 = g010;
    assign ifc.i_001 = g001;

    grey_display #(.pHOLD(3), .pBLANK(1'b1)) u_a (
        .i_clk(clk), .i_rst(rst), .bus(ifa));
    grey_display #(.pHOLD(3), .pBLANK(1'b0)) u_b (
        .i_clk(clk), .i_rst(rst), .bus(ifb));
    grey_display #(.pHOLD(1), .pBLANK(1'b1)) u_c (
        .i_clk(clk), .i_rst(rst), .bus(ifc));

    logic [7:0] led  [3];
    logic       busy [3];
    logic       err  [3];
    assign led[0] = ifa.o_LED;
    assign led[1] = ifb.o_LED;
    assign led[2] = ifc.o_LED;
    assign busy[0] = ifa.o_busy;
    assign busy[1] = ifb.o_busy;
    assign busy[2] = ifc.o_busy;
    assign err[0] = ifa.o_err;
    assign err[1] = ifb.o_err;
    assign err[2] = ifc.o_err;

    // Model: a sequence is just (start edge, three digits); outputs
    // follow from how many edges have passed since the start.
    int hold [3] = '{3, 3, 1};
    bit blk  [3] = '{1'b1, 1'b0, 1'b1};
    int lut  [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66,
                      'h6D, 'h7D, 'h07, 'h7F, 'h6F};
    bit act  [3];
    int s    [3];
    int mh   [3];
    int mt   [3];
    int mu   [3];
    bit merr [3];
    int ecnt = 0;

    function automatic int decode(input logic [4:0] g);
        for (int d = 0; d < 32; d++) begin
            if (5'(d ^ (d >> 1)) == g) return d;
        end
        return 0;
    endfunction

    function automatic int shown(input int v, input bit blank);
        if (v > 9) return 'h79;
        if (blank) return 0;
        return lut[v];
    endfunction

    function automatic bit m_busy(input int i, input int cur);
        return act[i] && (cur - s[i]) <= 4 * hold[i] - 1;
    endfunction

    function automatic logic [7:0] m_led(input int i);
        int slot;
        if (!m_busy(i, ecnt)) return 8'h00;
        slot = (ecnt - s[i]) / hold[i];
        case (slot)
            0: return 8'(shown(mh[i], blk[i] && mh[i] == 0) | 'h80);
            1: return 8'(shown(mt[i], blk[i] && mh[i] == 0 && mt[i] == 0));
            2: return 8'(shown(mu[i], 1'b0));
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        int e;
        e = ecnt + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                act[i]  = 1'b0;
                merr[i] = 1'b0;
            end else if (ld[i] && !m_busy(i, e - 1)) begin
                act[i]  = 1'b1;
                s[i]    = e;
                mh[i]   = decode(g100);
                mt[i]   = decode(g010);
                mu[i]   = decode(g001);
                merr[i] = mh[i] > 9 || mt[i] > 9 || mu[i] > 9;
            end
        end
        ecnt = e;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (led[i] !== m_led(i)) begin
                    bad++;
                    $display("FAIL model_led[%0d] edge=%0d got=%h want=%h",
                             i, ecnt, led[i], m_led(i));
                end
                total++;
                if (busy[i] !== m_busy(i, ecnt)) begin
                    bad++;
                    $display("FAIL model_busy[%0d] edge=%0d got=%b want=%b",
                             i, ecnt, busy[i], m_busy(i, ecnt));
                end
                total++;
                if (err[i] !== merr[i]) begin
                    bad++;
                    $display("FAIL model_err[%0d] edge=%0d got=%b want=%b",
                             i, ecnt, err[i], merr[i]);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] a,
                       input logic [7:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, a, x);
        end
    endtask

    logic [7:0] exp_742 [13] = '{8'h87, 8'h87, 8'h87, 8'h66, 8'h66,
                                 8'h66, 8'h5B, 8'h5B, 8'h5B, 8'h00,
                                 8'h00, 8'h00, 8'h00};

    initial begin
        step(1);
        chk_en = 1'b1;
        step(1);
        chk("rst_led", led[0], 8'h00);
        chk("rst_busy", {7'b0, busy[0]}, 8'h00);
        chk("rst_err", {7'b0, err[0]}, 8'h00);
        rst = 1'b0;
        step(2);

        // 7,4,2
        g100 = 5'h04; g010 = 5'h06; g001 = 5'h03;
        ld = 3'b011; step(1); ld = 3'b000;
        for (int k = 0; k < 13; k++) begin
            chk("led_742", led[0], exp_742[k]);
            chk("busy_742", {7'b0, busy[0]}, (k < 12) ? 8'h01 : 8'h00);
            step(1);
        end
        chk("err_742", {7'b0, err[0]}, 8'h00);

        // 0,0,5 with and without blanking
        g100 = 5'h00; g010 = 5'h00; g001 = 5'h07;
        ld = 3'b011; step(1); ld = 3'b000;
        chk("d100_blank", led[0], 8'h80);
        chk("d100_noblank", led[1], 8'hBF);
        step(3);
        chk("d010_blank", led[0], 8'h00);
        chk("d010_noblank", led[1], 8'h3F);
        step(3);
        chk("d001_005", led[0], 8'h6D);
        chk("d001_005b", led[1], 8'h6D);
        step(3);
        chk("gap_005", led[0], 8'h00);
        chk("gap_busy", {7'b0, busy[0]}, 8'h01);
        step(3);
        chk("idle_005", {7'b0, busy[0]}, 8'h00);
        step(1);

        // invalid hundreds (21), 9, 0
        g100 = 5'h1F; g010 = 5'h0D; g001 = 5'h00;
        ld = 3'b001; step(1); ld = 3'b000;
        chk("err_d100", led[0], 8'hF9);
        chk("err_set", {7'b0, err[0]}, 8'h01);
        step(3);
        chk("err_d010", led[0], 8'h6F);
        step(3);
        chk("err_d001", led[0], 8'h3F);
        step(6);
        chk("err_held", {7'b0, err[0]}, 8'h01);
        g100 = 5'h04; g010 = 5'h06; g001 = 5'h03;
        ld = 3'b001; step(1); ld = 3'b000;
        chk("err_clear", {7'b0, err[0]}, 8'h00);
        chk("err_next", led[0], 8'h87);
        step(13);

        // load while busy is dropped
        g100 = 5'h01; g010 = 5'h03; g001 = 5'h02;
        ld = 3'b001; step(1); ld = 3'b000;
        chk("ign_d100", led[0], 8'h86);
        step(6);
        chk("ign_d001", led[0], 8'h4F);
        g100 = 5'h0D; g010 = 5'h0D; g001 = 5'h0D;
        ld = 3'b001; step(1); ld = 3'b000;
        chk("ign_kept", led[0], 8'h4F);
        step(2);
        chk("ign_gap", {7'b0, busy[0]}, 8'h01);
        step(3);
        chk("ign_idle", {7'b0, busy[0]}, 8'h00);
        step(1);

        // reset mid-D010
        g100 = 5'h1F; g010 = 5'h0D; g001 = 5'h00;
        ld = 3'b001; step(1); ld = 3'b000;
        step(4);
        chk("mid_d010", led[0], 8'h6F);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("mid_rst_led", led[0], 8'h00);
        chk("mid_rst_busy", {7'b0, busy[0]}, 8'h00);
        chk("mid_rst_err", {7'b0, err[0]}, 8'h00);
        g100 = 5'h04; g010 = 5'h06; g001 = 5'h03;
        ld = 3'b001; step(1); ld = 3'b000;
        chk("restart", led[0], 8'h87);
        step(13);

        // reset beats a simultaneous load
        rst = 1'b1; ld = 3'b111; step(1); rst = 1'b0; ld = 3'b000;
        chk("rst_vs_load", {7'b0, busy[0]}, 8'h00);
        step(2);

        // pHOLD=1 back-to-back 9,9,9
        g100 = 5'h0D; g010 = 5'h0D; g001 = 5'h0D;
        for (int r = 0; r < 2; r++) begin
            ld = 3'b100; step(1); ld = 3'b000;
            chk("h1_d100", led[2], 8'hEF);
            step(1);
            chk("h1_d010", led[2], 8'h6F);
            step(1);
            chk("h1_d001", led[2], 8'h6F);
            step(1);
            chk("h1_gap", led[2], 8'h00);
            chk("h1_gap_busy", {7'b0, busy[2]}, 8'h01);
            step(1);
            chk("h1_idle", {7'b0, busy[2]}, 8'h00);
        end
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/grey_display.md
# grey_display

Sequencer that takes one captured three-digit grey-coded count (hundreds, tens and units digits, 5 bits each) and decodes it back to decimal. It then presents the digits one at a time as seven-segment patterns on the 8-bit LED bus. It sits downstream of the capture stage in the `i_clk` domain and is the decode end of the `grey_1000` digit encoding. Each digit is held for a programmable number of cycles, so a human or a slow logic probe can read the full value off a single 7-segment display.

## Interface
- `pHOLD`, default 1000: cycles each digit (and the trailing gap) is held on `o_LED`; legal range 1..65535.
- `pBLANK`, default 1: 1 = leading-zero blanking on the hundreds and tens digits; 0 = always show all three digits.
- `i_clk`, in, 1: sole clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_load`, in, 1: single-cycle strobe; samples `i_100`/`i_010`/`i_001` when accepted.
- `i_100`, in, 5: hundreds digit, grey-coded.
- `i_010`, in, 5: tens digit, grey-coded.
- `i_001`, in, 5: units digit, grey-coded.
- `o_LED`, out, 8: segment pattern; bit7 = DP, bits6:0 = g,f,e,d,c,b,a; 1 = lit.
- `o_busy`, out, 1: high while a display sequence is in progress; loads are ignored while high.
- `o_err`, out, 1: sticky flag; set if any digit of the current sequence decoded to a value above 9.

## Operation
- **Digit encoding:** a digit `d` in 0..9 is encoded as `g = d ^ (d>>1)` in 5 bits.
- **Decode:** `b[4] = g[4]`, then `b[i] = b[i+1] ^ g[i]` for i = 3..0. A digit is valid iff b ≤ 9.
- **Load acceptance:** `i_load` is accepted only in IDLE. On acceptance:
  - all three decoded digits are registered;
  - `o_err` is recomputed as the OR of the three invalid flags.
- **Segment patterns:** 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - An invalid digit shows 79 ('E').
  - A blanked digit shows 00.
- **DP:** bit7 is set during D100 only, marking the start of a sequence.
- **Blanking (`pBLANK` = 1):**
  - hundreds is blanked if its value is 0;
  - tens is blanked if hundreds = 0 and tens = 0;
  - units is never blanked;
  - an invalid digit is never blanked.
  - DP is still lit when the hundreds digit is blanked (`o_LED` = 80).
- **FSM states:** IDLE, D100, D010, D001, GAP.
  - IDLE → D100 on an accepted load.
  - D100 → D010 → D001 → GAP → IDLE, each transition after `pHOLD` cycles in the state.
  - `o_LED` = 00 in IDLE and GAP.
  - `o_busy` = 1 in every state except IDLE.
- **Hold counter:** width `$clog2(pHOLD+1)`. It is cleared on every state entry and the state advances when the count reaches `pHOLD`-1.
- **Loads while busy:** `i_load` while `o_busy` = 1 is dropped, with no queueing.
- **Reset values** (apply in any state, including mid-sequence): IDLE, `o_LED` = 00, `o_busy` = 0, `o_err` = 0, hold counter 0, digit registers 0.

## Timing
- Load sampled at edge n: `o_busy` = 1 and the D100 pattern appear at n+1. All outputs are registered.
- Digit windows:
  - D100 occupies cycles n+1 .. n+pHOLD;
  - D010 occupies n+pHOLD+1 .. n+2·pHOLD;
  - D001 occupies n+2·pHOLD+1 .. n+3·pHOLD;
  - GAP occupies n+3·pHOLD+1 .. n+4·pHOLD.
- End of sequence: `o_busy` falls at n+4·pHOLD+1. A load at that same edge is accepted, giving a back-to-back repeat interval of 4·pHOLD+1 cycles.
- **`pHOLD` = 1:** one cycle per state, no special casing.
- **Simultaneous `i_rst` and `i_load`:** reset wins and the load is discarded.
- **`o_err`:** valid from n+1 and held until the next accepted load or reset.

## Test plan
- Reset mid-D010 with `pHOLD` = 3 → next cycle `o_LED` = 00, `o_busy` = 0, `o_err` = 0; a following load restarts at D100.
- Load 7,4,2 (grey 04,06,03), `pBLANK` = 1, `pHOLD` = 3 → `o_LED` = 87×3, 66×3, 5B×3, 00×3. `o_busy` is high for exactly 12 cycles; `o_err` = 0.
- Load 0,0,5 with `pBLANK` = 1 → 80, 00, 6D, 00. With `pBLANK` = 0 → BF, 3F, 6D, 00.
- Load hundreds grey 1F (decodes to 21, invalid), tens 9, units 0 → D100 shows F9 (79 plus DP); `o_err` = 1 from cycle n+1 through the end of the sequence. It clears on the next valid load.
- Second `i_load` pulsed during D001 with different digits → ignored; the displayed values are unchanged; IDLE is reached at n+13 (`pHOLD` = 3).
- `pHOLD` = 1, load 9,9,9 then re-pulse `i_load` at the first IDLE cycle → EF, 6F, 6F, 00, and an immediate second identical sequence with no extra idle cycle.
